// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module      : regfile_pkg
// Description : Shared constants and types for the scoreboarded register
//               file: default geometry, the hard-wired zero register index
//               and the scoreboard counter type.
// Revision    : 1.0 - initial release
// ============================================================================
package regfile_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 32;
    localparam int CNTW_DEF  = 2;

    // Architectural register that always reads as zero and is never tracked.
    localparam int REG_ZERO  = 0;

    typedef logic [CNTW_DEF-1:0] sb_cnt_t;

endpackage
`default_nettype wire

// File: rtl/regfile_sb_cnt.sv
`default_nettype none
// ============================================================================
// Module      : regfile_sb_cnt
// Description : One scoreboard entry: a saturating up/down counter of
//               in-flight writes to a single register.
//               Ports:
//                 clk, rst  - clock, synchronous active-high reset
//                 inc       - an issue targeting this register was accepted
//                 dec       - a writeback targets this register (raw hit)
//                 clr       - drop all tracking (pipeline flush)
//                 cnt       - current pending-write count
//                 uflow     - writeback hit while the count is already zero
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_sb_cnt
    import regfile_pkg::*;
#(
    parameter int CNTW = CNTW_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            inc,
    input  logic            dec,
    input  logic            clr,
    output logic [CNTW-1:0] cnt,
    output logic            uflow
);

    logic [CNTW-1:0] r_cnt;
    logic            w_empty;
    logic            w_full;
    logic            w_dec_ok;

    assign w_empty  = (r_cnt == '0);
    assign w_full   = &r_cnt;
    // A writeback only retires a pending write if one exists; otherwise it is
    // reported as an underflow and the count stays at zero.
    assign w_dec_ok = dec && !w_empty;
    assign uflow    = dec && w_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (inc && !w_dec_ok) begin
            if (!w_full) begin
                r_cnt <= r_cnt + CNTW'(1);
            end
        end else if (w_dec_ok && !inc) begin
            r_cnt <= r_cnt - CNTW'(1);
        end
    end

    assign cnt = r_cnt;

endmodule
`default_nettype wire

// File: rtl/regfile_sb.sv
`default_nettype none
// ============================================================================
// Module      : regfile_sb
// Description : Integer register file with NRD combinational read ports, one
//               rising-edge write port, hard-wired zero register and a
//               per-register pending-write scoreboard.
//               Optional macro REGFILE_SB_BYPASS_EN: same-cycle write data is
//               forwarded to matching read ports and the retiring write
//               clears rd_busy in the same cycle.
//               Ports:
//                 clk, rst            - clock, synchronous active-high reset
//                 rd_addr / rd_data   - packed read ports (k*AW / k*XLEN)
//                 rd_busy             - per-port pending-write flag
//                 we, wa, wd          - writeback port
//                 iss_valid, iss_rd   - destination issued from ID
//                 iss_ready           - scoreboard can accept iss_rd
//                 flush               - clear all pending-write tracking
//                 wb_err              - sticky writeback-without-issue error
//                 probe_data          - live value of register PROBE_IDX
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int XLEN      = XLEN_DEF,
    parameter int NREGS     = NREGS_DEF,
    parameter int NRD       = 2,
    parameter int CNTW      = CNTW_DEF,
    parameter int PROBE_IDX = 7,
    localparam int AW       = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_busy,
    input  logic                we,
    input  logic [AW-1:0]       wa,
    input  logic [XLEN-1:0]     wd,
    input  logic                iss_valid,
    input  logic [AW-1:0]       iss_rd,
    output logic                iss_ready,
    input  logic                flush,
    output logic                wb_err,
    output logic [XLEN-1:0]     probe_data
);

    logic [XLEN-1:0] r_mem [NREGS];
    logic [CNTW-1:0] w_cnt [NREGS];
    logic [NREGS-1:0] w_uflow;
    logic            r_wb_err;
    logic            w_wr;
    logic            w_issue;

    assign w_wr      = we && (wa != AW'(REG_ZERO));
    assign iss_ready = !(iss_valid && (iss_rd != AW'(REG_ZERO)) && (&w_cnt[iss_rd]));
    assign w_issue   = iss_valid && iss_ready && (iss_rd != AW'(REG_ZERO));

    // ------------------------------------------------------------------
    // Register storage: entry 0 is cleared on reset and never written.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_wr) begin
            r_mem[wa] <= wd;
        end
    end

    // ------------------------------------------------------------------
    // Scoreboard: one counter per non-zero register.
    // ------------------------------------------------------------------
    assign w_cnt[0]   = '0;
    assign w_uflow[0] = 1'b0;

    for (genvar r = 1; r < NREGS; r++) begin : g_cnt
        logic w_inc;
        logic w_dec;

        assign w_inc = w_issue && (iss_rd == AW'(r));
        assign w_dec = w_wr && (wa == AW'(r));

        regfile_sb_cnt #(
            .CNTW (CNTW)
        ) u_cnt (
            .clk   (clk),
            .rst   (rst),
            .inc   (w_inc),
            .dec   (w_dec),
            .clr   (flush),
            .cnt   (w_cnt[r]),
            .uflow (w_uflow[r])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wb_err <= 1'b0;
        end else if (|w_uflow) begin
            r_wb_err <= 1'b1;
        end
    end

    assign wb_err = r_wb_err;

    // ------------------------------------------------------------------
    // Read ports.
    // ------------------------------------------------------------------
    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0]   w_a;
        logic [XLEN-1:0] w_q;
        logic            w_pend;

        assign w_a    = rd_addr[k*AW +: AW];
        assign w_pend = (w_cnt[w_a] != '0);

`ifdef REGFILE_SB_BYPASS_EN
        logic w_hit;

        assign w_hit = w_wr && (wa == w_a);
        assign w_q   = w_hit ? wd : r_mem[w_a];
        // The write landing this cycle retires the last outstanding write,
        // so the forwarded value is already final.
        assign rd_busy[k] = w_pend && !(w_hit && (w_cnt[w_a] == CNTW'(1)));
`else
        assign w_q        = r_mem[w_a];
        assign rd_busy[k] = w_pend;
`endif

        assign rd_data[k*XLEN +: XLEN] = (w_a == AW'(REG_ZERO)) ? '0 : w_q;
    end

    assign probe_data = r_mem[AW'(PROBE_IDX)];

endmodule
`default_nettype wire

// File: tb/tb_regfile_sb.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_sb
// Description : Self-checking bench for regfile_sb: reset sweep, a directed
//               vector table for the multi-cycle scoreboard corner cases and
//               a randomized run against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_sb;
    import regfile_pkg::*;

    localparam int XLEN      = 32;
    localparam int NREGS     = 32;
    localparam int NRD       = 2;
    localparam int CNTW      = 2;
    localparam int PROBE_IDX = 7;
    localparam int AW        = 5;
    localparam int MAXC      = (1 << CNTW) - 1;
    localparam int NVEC      = 28;
`ifdef REGFILE_SB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic                clk = 1'b0;
    logic                rst;
    logic [NRD*AW-1:0]   rd_addr;
    logic [NRD*XLEN-1:0] rd_data;
    logic [NRD-1:0]      rd_busy;
    logic                we;
    logic [AW-1:0]       wa;
    logic [XLEN-1:0]     wd;
    logic                iss_valid;
    logic [AW-1:0]       iss_rd;
    logic                iss_ready;
    logic                flush;
    logic                wb_err;
    logic [XLEN-1:0]     probe_data;

    always #5 clk = ~clk;

    regfile_sb #(
        .XLEN      (XLEN),
        .NREGS     (NREGS),
        .NRD       (NRD),
        .CNTW      (CNTW),
        .PROBE_IDX (PROBE_IDX)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rd_busy    (rd_busy),
        .we         (we),
        .wa         (wa),
        .wd         (wd),
        .iss_valid  (iss_valid),
        .iss_rd     (iss_rd),
        .iss_ready  (iss_ready),
        .flush      (flush),
        .wb_err     (wb_err),
        .probe_data (probe_data)
    );

    // ------------------------------------------------------------------
    // Behavioural model: architectural contents, pending counts, error flag.
    // ------------------------------------------------------------------
    logic [XLEN-1:0] m_mem [NREGS];
    int              m_cnt [NREGS];
    bit              m_err;
    int              checks = 0;
    int              errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [XLEN-1:0] exp_rd(input logic [AW-1:0] a);
        if (a == 0) return '0;
        if (BYP && we && wa != 0 && wa == a) return wd;
        return m_mem[a];
    endfunction

    function automatic bit exp_busy(input logic [AW-1:0] a);
        bit hit;
        hit = we && (wa != 0) && (wa == a);
        if (m_cnt[a] == 0) return 1'b0;
        if (BYP && hit && m_cnt[a] == 1) return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit exp_ready();
        return !(iss_valid && iss_rd != 0 && m_cnt[iss_rd] == MAXC);
    endfunction

    task automatic model_check();
        logic [AW-1:0] a0;
        logic [AW-1:0] a1;
        a0 = rd_addr[0 +: AW];
        a1 = rd_addr[AW +: AW];
        chk("rd_data",    64'(rd_data),    {exp_rd(a1), exp_rd(a0)});
        chk("rd_busy",    64'(rd_busy),    64'({exp_busy(a1), exp_busy(a0)}));
        chk("iss_ready",  64'(iss_ready),  64'(exp_ready()));
        chk("wb_err",     64'(wb_err),     64'(m_err));
        chk("probe_data", 64'(probe_data), 64'(m_mem[PROBE_IDX]));
    endtask

    task automatic model_update();
        bit rdy;
        bit inc;
        bit dec;
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                m_mem[i] = '0;
                m_cnt[i] = 0;
            end
            m_err = 1'b0;
            return;
        end
        rdy = exp_ready();
        inc = iss_valid && rdy && (iss_rd != 0) && !flush;
        dec = we && (wa != 0) && (m_cnt[wa] != 0);
        if (we && wa != 0) begin
            if (m_cnt[wa] == 0) m_err = 1'b1;
            m_mem[wa] = wd;
        end
        if (flush) begin
            for (int i = 0; i < NREGS; i++) m_cnt[i] = 0;
        end else begin
            if (inc) m_cnt[iss_rd] = m_cnt[iss_rd] + 1;
            if (dec) m_cnt[wa] = m_cnt[wa] - 1;
        end
    endtask

    // Inputs are driven 1 time unit after a rising edge; outputs are sampled
    // on the falling edge, the model advances on the rising edge.
    task automatic tick(input bit do_check);
        #4;
        if (do_check) model_check();
        @(posedge clk);
        model_update();
        #1;
    endtask

    // ------------------------------------------------------------------
    // Directed vector table.
    // ------------------------------------------------------------------
    typedef struct {
        bit              rst;
        bit              we;
        logic [AW-1:0]   wa;
        logic [XLEN-1:0] wd;
        bit              iv;
        logic [AW-1:0]   ird;
        bit              fl;
        logic [AW-1:0]   a0;
        logic [AW-1:0]   a1;
        logic [XLEN-1:0] e_d0;
        logic [1:0]      e_busy;
        bit              e_rdy;
        bit              e_err;
    } vec_t;

    vec_t tbl [NVEC];

    function automatic int sel(input int on, input int off);
        return BYP ? on : off;
    endfunction

    function automatic vec_t mk(input int r, input int w, input int a, input int d,
                                input int iv, input int ird, input int fl,
                                input int a0, input int a1, input int ed0,
                                input int eb, input int erdy, input int eerr);
        vec_t v;
        v.rst    = r[0];
        v.we     = w[0];
        v.wa     = AW'(a);
        v.wd     = XLEN'(d);
        v.iv     = iv[0];
        v.ird    = AW'(ird);
        v.fl     = fl[0];
        v.a0     = AW'(a0);
        v.a1     = AW'(a1);
        v.e_d0   = XLEN'(ed0);
        v.e_busy = 2'(eb);
        v.e_rdy  = erdy[0];
        v.e_err  = eerr[0];
        return v;
    endfunction

    initial begin
        //              rst we wa  wd            iv ird fl a0 a1  exp_d0                    busy         rdy err
        tbl[0]  = mk(0, 0, 0, 0,            1, 5,  0, 5, 0, 0,                        0,           1, 0);
        tbl[1]  = mk(0, 1, 5, 'hDEADBEEF,   0, 0,  0, 5, 0, sel('hDEADBEEF, 0),       sel(0, 1),   1, 0);
        tbl[2]  = mk(0, 0, 0, 0,            0, 0,  0, 5, 0, 'hDEADBEEF,               0,           1, 0);
        tbl[3]  = mk(0, 1, 0, 'h1234,       0, 0,  0, 0, 0, 0,                        0,           1, 0);
        tbl[4]  = mk(0, 0, 0, 0,            0, 0,  0, 0, 0, 0,                        0,           1, 0);
        tbl[5]  = mk(0, 0, 0, 0,            1, 3,  0, 3, 0, 0,                        0,           1, 0);
        tbl[6]  = mk(0, 0, 0, 0,            1, 3,  0, 3, 0, 0,                        1,           1, 0);
        tbl[7]  = mk(0, 0, 0, 0,            1, 3,  0, 3, 0, 0,                        1,           1, 0);
        tbl[8]  = mk(0, 0, 0, 0,            1, 3,  0, 3, 0, 0,                        1,           0, 0);
        tbl[9]  = mk(0, 1, 3, 'h11,         0, 0,  0, 3, 0, sel('h11, 0),             1,           1, 0);
        tbl[10] = mk(0, 1, 3, 'h22,         0, 0,  0, 3, 0, sel('h22, 'h11),          1,           1, 0);
        tbl[11] = mk(0, 1, 3, 'h33,         0, 0,  0, 3, 0, sel('h33, 'h22),          sel(0, 1),   1, 0);
        tbl[12] = mk(0, 0, 0, 0,            0, 0,  0, 3, 0, 'h33,                     0,           1, 0);
        tbl[13] = mk(0, 0, 0, 0,            1, 4,  0, 4, 0, 0,                        0,           1, 0);
        tbl[14] = mk(0, 1, 4, 'h44,         1, 4,  0, 4, 0, sel('h44, 0),             sel(0, 1),   1, 0);
        tbl[15] = mk(0, 0, 0, 0,            0, 0,  0, 4, 0, 'h44,                     1,           1, 0);
        tbl[16] = mk(0, 1, 9, 'h99,         0, 0,  0, 9, 0, sel('h99, 0),             0,           1, 0);
        tbl[17] = mk(0, 0, 0, 0,            0, 0,  0, 9, 0, 'h99,                     0,           1, 1);
        tbl[18] = mk(1, 0, 0, 0,            0, 0,  0, 9, 0, 'h99,                     0,           1, 1);
        tbl[19] = mk(0, 0, 0, 0,            0, 0,  0, 9, 0, 0,                        0,           1, 0);
        tbl[20] = mk(0, 0, 0, 0,            1, 7,  0, 7, 0, 0,                        0,           1, 0);
        tbl[21] = mk(0, 0, 0, 0,            1, 8,  0, 7, 8, 0,                        1,           1, 0);
        tbl[22] = mk(0, 1, 7, 'h55,         1, 7,  1, 7, 8, sel('h55, 0),             sel(2, 3),   1, 0);
        tbl[23] = mk(0, 0, 0, 0,            0, 0,  0, 7, 8, 'h55,                     0,           1, 0);
        tbl[24] = mk(0, 0, 0, 0,            1, 7,  0, 7, 0, 'h55,                     0,           1, 0);
        tbl[25] = mk(0, 0, 0, 0,            1, 7,  0, 7, 0, 'h55,                     1,           1, 0);
        tbl[26] = mk(1, 1, 7, 'h77,         0, 0,  0, 7, 0, sel('h77, 'h55),          1,           1, 0);
        tbl[27] = mk(0, 0, 0, 0,            0, 0,  0, 7, 0, 0,                        0,           1, 0);

        for (int i = 0; i < NREGS; i++) begin
            m_mem[i] = '0;
            m_cnt[i] = 0;
        end
        m_err = 1'b0;

        // Reset with every other input quiet.
        rst       = 1'b1;
        we        = 1'b0;
        wa        = '0;
        wd        = '0;
        iss_valid = 1'b0;
        iss_rd    = '0;
        flush     = 1'b0;
        rd_addr   = '0;
        tick(1'b0);
        tick(1'b0);
        rst = 1'b0;

        // Reset sweep across every register on both ports.
        for (int i = 0; i < NREGS; i++) begin
            rd_addr = {AW'(NREGS - 1 - i), AW'(i)};
            tick(1'b1);
        end

        // Directed table.
        for (int i = 0; i < NVEC; i++) begin
            rst       = tbl[i].rst;
            we        = tbl[i].we;
            wa        = tbl[i].wa;
            wd        = tbl[i].wd;
            iss_valid = tbl[i].iv;
            iss_rd    = tbl[i].ird;
            flush     = tbl[i].fl;
            rd_addr   = {tbl[i].a1, tbl[i].a0};
            #4;
            chk($sformatf("vec%0d_rd_data0", i), 64'(rd_data[XLEN-1:0]), 64'(tbl[i].e_d0));
            chk($sformatf("vec%0d_rd_busy", i),  64'(rd_busy),           64'(tbl[i].e_busy));
            chk($sformatf("vec%0d_iss_ready", i), 64'(iss_ready),        64'(tbl[i].e_rdy));
            chk($sformatf("vec%0d_wb_err", i),   64'(wb_err),            64'(tbl[i].e_err));
            model_check();
            @(posedge clk);
            model_update();
            #1;
        end

        // Randomized traffic over a small register window so counters
        // saturate, drain and underflow frequently.
        for (int n = 0; n < 400; n++) begin
            rst       = ($urandom_range(0, 99) == 0);
            flush     = ($urandom_range(0, 29) == 0);
            we        = $urandom_range(0, 1) == 1;
            wa        = AW'($urandom_range(0, 7));
            wd        = $urandom;
            iss_valid = ($urandom_range(0, 2) != 0);
            iss_rd    = AW'($urandom_range(0, 7));
            rd_addr[0 +: AW]  = ($urandom_range(0, 3) == 0) ? wa : AW'($urandom_range(0, 7));
            rd_addr[AW +: AW] = ($urandom_range(0, 3) == 0) ? iss_rd : AW'($urandom_range(0, 9));
            tick(1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised successor to the pipeline integer register file: NRD combinational read ports, one write port, hard-wired zero register, and a per-register pending-write scoreboard.
- Sits in ID (reads, hazard query) and WB (write); the hazard unit uses rd_busy/iss_ready to stall.
- Writes move to the rising edge.
- Optional same-cycle write-to-read bypass replaces the old negedge-write trick.

Parameters:
- XLEN, 32, data width of each register.
- NREGS, 32, number of architectural registers (power of 2, >=2); AW = $clog2(NREGS) is a derived localparam.
- NRD, 2, number of read ports (1..4).
- CNTW, 2, scoreboard counter width; max in-flight writes per register = 2**CNTW-1.
- PROBE_IDX, 7, register index driven on probe_data.

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- rd_addr  in  NRD*AW  read addresses, port k at [k*AW +: AW].
- rd_data  out  NRD*XLEN  read data, port k at [k*XLEN +: XLEN].
- rd_busy  out  NRD  port k address has a pending write.
- we  in  1  writeback enable.
- wa  in  AW  writeback address.
- wd  in  XLEN  writeback data.
- iss_valid  in  1  instruction with a destination leaves ID this cycle.
- iss_rd  in  AW  its destination register.
- iss_ready  out  1  scoreboard can accept iss_rd.
- flush  in  1  discard all pending-write tracking (pipeline flush).
- wb_err  out  1  sticky: writeback to a register with zero pending count.
- probe_data  out  XLEN  live value of register PROBE_IDX.

Behaviour:
- Reset (rst=1 at posedge): all registers 0, all counters 0, wb_err 0. Reset has priority over we, iss_valid and flush.
- Reads are combinational, zero latency. rd_data reflects register contents after the last edge, or the bypass value when enabled.
- Reads of index 0 always return 0.
- Write: at posedge, if we && wa!=0, then mem[wa] <= wd. Writes to index 0 are discarded.
- Scoreboard: one CNTW-bit counter cnt[r] per register; cnt[0] is constant 0. Per edge, for r != 0:
  - inc = iss_valid && iss_ready && iss_rd==r
  - dec = we && wa==r && cnt[r]!=0
  - inc and dec together: unchanged. inc only: +1. dec only: -1.
- iss_ready = !(iss_valid && iss_rd!=0 && cnt[iss_rd]==all-ones). Issue to x0 is always ready and never counted.
- iss_valid while iss_ready=0: no counter change.
- Underflow: we && wa!=0 && cnt[wa]==0. The data write still happens, the counter stays 0, and wb_err sets and holds until rst.
- flush=1: all counters cleared at the edge; same-cycle write still commits data; same-cycle issue is ignored.
- rd_busy[k] = cnt[rd_addr_k]!=0, subject to the bypass exception below.
- probe_data = mem[PROBE_IDX], combinational, 0 after reset.

Optional Feature:
- Macro REGFILE_SB_BYPASS_EN.
- Defined:
  - If we && wa!=0 && wa==rd_addr_k, then rd_data port k = wd in the same cycle.
  - rd_busy[k] is forced 0 when the same-cycle write retires the last pending write, i.e. cnt==1.
- Undefined:
  - rd_data shows the pre-write value until the following cycle.
  - rd_busy[k] stays 1 that cycle.
  - The hazard unit must stall one extra cycle.

Decomposition:
- Shared package regfile_pkg:
  - default XLEN/NREGS/CNTW constants
  - REG_ZERO index constant
  - typedef for the scoreboard counter
- One natural sub-module, regfile_sb_cnt: a single saturating up/down counter with inc, dec, clr and rst, instantiated NREGS-1 times via generate. It flags the underflow attempt.
- Read muxing and bypass stay in the top module.

Test Plan:
- Reset then read all ports over x0..x31 -> all rd_data 0, rd_busy 0, iss_ready 1, wb_err 0, probe_data 0.
- we=1 wa=5 wd=0xDEADBEEF, rd_addr0=5 same cycle:
  - bypass on: rd_data0=0xDEADBEEF immediately.
  - bypass off: old 0, then 0xDEADBEEF next cycle.
  - we=1 wa=0 wd=0x1234: x0 reads 0.
- Issue x3 three times (CNTW=2) -> cnt=3, rd_busy for x3 =1. Fourth issue -> iss_ready=0 and count unchanged. Three writebacks to x3 -> rd_busy 0 after the third.
- Same-cycle issue x4 and writeback x4 with cnt=1 -> cnt stays 1, data written, rd_busy=1.
- Writeback x9 with cnt=0 -> mem[9] updated, wb_err=1 and stays 1. rst -> wb_err=0.
- Issue x7, x8, then flush with we wa=7 wd=0x55 -> all rd_busy 0, probe_data=0x55.
- rst asserted mid-flight with cnt[7]=2 and we active -> all 0 next cycle.
